fetch_buffer: RTL and testbench

- Instruction-fetch stage directly downstream of the PC register.
- Issues one instruction-memory read per PC value, tolerates variable memory latency, and buffers fetched {pc, instruction} pairs in a small FIFO for the decode stage.
- Holds the PC register through its stop input whenever it cannot accept a new fetch.
- Discards buffered and in-flight fetches on a branch redirect.

---
 rtl/fetch_buffer.sv | 169 ++++++++++++++++
 tb/tb_fetch_buffer.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_buffer.sv
// fetch_buffer
// Instruction-fetch stage that sits directly after the PC register.
// It issues one instruction-memory read per PC value and allows only one
// read to be outstanding at a time. Returned {pc, instruction} pairs are
// queued in a small FIFO for the decode stage. A branch redirect (flush)
// empties the FIFO and throws away the data of any read still in flight.
//
// Ports
//   clock           : single clock, rising edge
//   reset           : asynchronous, active-low reset
//   program_counter : current PC from the PC register
//   chip_enable     : PC register enable; fetch only when high
//   flush           : branch redirect (asserted with the PC register's branch)
//   stop_fetch      : drives stop_all[0] of the PC register; 1 = hold PC
//   imem_req        : memory read request
//   imem_address    : read address (always program_counter)
//   imem_ready      : memory accepts the request this cycle
//   imem_rvalid     : read data valid
//   imem_rdata      : read data
//   id_valid        : FIFO head valid to decode
//   id_pc           : PC of the head entry
//   id_instruction  : instruction of the head entry
//   id_ready        : decode consumes the head this cycle
module fetch_buffer #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] program_counter,
  input  logic              chip_enable,
  input  logic              flush,
  output logic              stop_fetch,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_address,
  input  logic              imem_ready,
  input  logic              imem_rvalid,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic              id_valid,
  output logic [ADDR_W-1:0] id_pc,
  output logic [DATA_W-1:0] id_instruction,
  input  logic              id_ready
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DROP = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [ADDR_W-1:0] pc_cap_q, pc_cap_d;
  logic [ADDR_W-1:0] pc_mem_q  [DEPTH];
  logic [DATA_W-1:0] ins_mem_q [DEPTH];

  logic not_full_s;
  logic accept_s;
  logic push_s;
  logic pop_s;

  assign not_full_s = (count_q < CNT_W'(DEPTH));
  // Gating with reset keeps the request low while reset is held, whatever
  // chip_enable is doing.
  assign imem_req = reset & (state_q == S_IDLE) & chip_enable & ~flush & not_full_s;
  assign accept_s = imem_req & imem_ready;
  // A flush in the same cycle as the returning data discards that data.
  assign push_s   = (state_q == S_WAIT) & imem_rvalid & ~flush;
  // A pop together with a flush is just a flush.
  assign pop_s    = (count_q != CNT_W'(0)) & id_ready & ~flush;

  assign imem_address   = program_counter;
  // Release the PC once per accepted request, and during a flush so the PC
  // register loads the branch target on that same edge.
  assign stop_fetch     = ~reset | ~(accept_s | flush);
  assign id_valid       = (count_q != CNT_W'(0));
  assign id_pc          = pc_mem_q[rd_ptr_q];
  assign id_instruction = ins_mem_q[rd_ptr_q];

  // Next-state logic for the request FSM and the FIFO bookkeeping.
  always_comb begin
    state_d  = state_q;
    pc_cap_d = pc_cap_q;
    count_d  = count_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;

    case (state_q)
      S_IDLE: begin
        if (accept_s) begin
          pc_cap_d = program_counter;
          state_d  = S_WAIT;
        end else begin
          state_d  = S_IDLE;
        end
      end
      S_WAIT: begin
        if (imem_rvalid) begin
          state_d = S_IDLE;
        end else if (flush) begin
          state_d = S_DROP;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_DROP: begin
        // The stale read still has to come back before a new one may go out.
        if (imem_rvalid) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_DROP;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (flush) begin
      count_d  = CNT_W'(0);
      wr_ptr_d = PTR_W'(0);
      rd_ptr_d = PTR_W'(0);
    end else begin
      count_d  = count_q + CNT_W'(push_s) - CNT_W'(pop_s);
      wr_ptr_d = wr_ptr_q + PTR_W'(push_s);
      rd_ptr_d = rd_ptr_q + PTR_W'(pop_s);
    end
  end

  // State, captured PC and FIFO control registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      count_q  <= CNT_W'(0);
      wr_ptr_q <= PTR_W'(0);
      rd_ptr_q <= PTR_W'(0);
      pc_cap_q <= ADDR_W'(0);
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      pc_cap_q <= pc_cap_d;
    end
  end

  // FIFO storage; the head is always read from these registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        pc_mem_q[i]  <= ADDR_W'(0);
        ins_mem_q[i] <= DATA_W'(0);
      end
    end else if (push_s) begin
      pc_mem_q[wr_ptr_q]  <= pc_cap_q;
      ins_mem_q[wr_ptr_q] <= imem_rdata;
    end else begin
      pc_mem_q[wr_ptr_q]  <= pc_mem_q[wr_ptr_q];
      ins_mem_q[wr_ptr_q] <= ins_mem_q[wr_ptr_q];
    end
  end

endmodule

// File: tb/tb_fetch_buffer.sv
// Self-checking bench for fetch_buffer. Stimulus plays the PC register and
// the instruction memory cycle by cycle; expected {pc, instruction} pairs are
// queued when data is returned and a monitor compares them whenever decode
// consumes the head entry.
module tb_fetch_buffer;

  logic        clock;
  logic        reset;
  logic [31:0] program_counter;
  logic        chip_enable;
  logic        flush;
  logic        stop_fetch;
  logic        imem_req;
  logic [31:0] imem_address;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        id_valid;
  logic [31:0] id_pc;
  logic [31:0] id_instruction;
  logic        id_ready;

  logic [31:0] target;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] ins;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp;
  int   n_fail;

  fetch_buffer #(.DEPTH(4), .ADDR_W(32), .DATA_W(32)) dut (
    .clock           (clock),
    .reset           (reset),
    .program_counter (program_counter),
    .chip_enable     (chip_enable),
    .flush           (flush),
    .stop_fetch      (stop_fetch),
    .imem_req        (imem_req),
    .imem_address    (imem_address),
    .imem_ready      (imem_ready),
    .imem_rvalid     (imem_rvalid),
    .imem_rdata      (imem_rdata),
    .id_valid        (id_valid),
    .id_pc           (id_pc),
    .id_instruction  (id_instruction),
    .id_ready        (id_ready)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic exp_push(input logic [31:0] pc, input logic [31:0] ins);
    exp_q.push_back({pc, ins});
  endtask

  // Let combinational outputs settle (posedge+1 -> posedge+4).
  task automatic settle();
    #3;
  endtask

  // Advance one clock; the PC register model updates when stop_fetch is low.
  task automatic tick();
    logic sf;
    logic fl;
    #2;
    sf = stop_fetch;
    fl = flush;
    @(posedge clock);
    #1;
    if (!sf) program_counter = fl ? target : program_counter + 32'd4;
  endtask

  // Scoreboard monitor: compare every head entry that decode consumes.
  always @(negedge clock) begin
    exp_t e;
    if (reset && !flush && id_valid && id_ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL sb_underflow: got pc 0x%08h with no expected entry", id_pc);
      end else begin
        e = exp_q.pop_front();
        chk("sb_pc", id_pc, e.pc);
        chk("sb_ins", id_instruction, e.ins);
      end
    end
  end

  initial begin
    n_cmp = 0;
    n_fail = 0;
    reset = 1'b0;
    program_counter = 32'h0;
    chip_enable = 1'b0;
    flush = 1'b0;
    imem_ready = 1'b1;
    imem_rvalid = 1'b0;
    imem_rdata = 32'h0;
    id_ready = 1'b0;
    target = 32'h0;

    repeat (2) @(posedge clock);
    #1;
    chip_enable = 1'b1;
    settle();
    chk("rst_id_valid", 32'(id_valid), 32'd0);
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_stop", 32'(stop_fetch), 32'd1);
    tick();
    reset = 1'b1;

    // Basic fetch at 0x0
    settle();
    chk("t1_req", 32'(imem_req), 32'd1);
    chk("t1_addr", imem_address, 32'h0);
    chk("t1_stop", 32'(stop_fetch), 32'd0);
    chk("t1_empty", 32'(id_valid), 32'd0);
    tick();
    imem_rvalid = 1'b1; imem_rdata = 32'h2402_0005; exp_push(32'h0, 32'h2402_0005);
    settle();
    chk("t1_wait_req", 32'(imem_req), 32'd0);
    chk("t1_wait_stop", 32'(stop_fetch), 32'd1);
    tick();
    imem_rvalid = 1'b0;
    settle();
    chk("t1_id_valid", 32'(id_valid), 32'd1);
    chk("t1_id_pc", id_pc, 32'h0);
    chk("t1_id_ins", id_instruction, 32'h2402_0005);
    chk("t1_next_req", 32'(imem_req), 32'd1);
    chk("t1_next_addr", imem_address, 32'h4);
    tick();

    // Fill the FIFO with decode stalled
    imem_rvalid = 1'b1; imem_rdata = 32'h8C01_0004; exp_push(32'h4, 32'h8C01_0004);
    tick();
    imem_rvalid = 1'b0;
    settle();
    chk("t2_addr8", imem_address, 32'h8);
    tick();
    imem_rvalid = 1'b1; imem_rdata = 32'h3C01_1000; exp_push(32'h8, 32'h3C01_1000);
    tick();
    imem_rvalid = 1'b0;
    settle();
    chk("t2_addrC", imem_address, 32'hC);
    tick();
    imem_rvalid = 1'b1; imem_rdata = 32'h0000_0013; exp_push(32'hC, 32'h0000_0013);
    tick();
    imem_rvalid = 1'b0;
    settle();
    chk("t2_full_req", 32'(imem_req), 32'd0);
    chk("t2_full_stop", 32'(stop_fetch), 32'd1);
    chk("t2_full_addr", imem_address, 32'h10);
    tick();
    settle();
    chk("t2_hold_req", 32'(imem_req), 32'd0);
    chk("t2_hold_stop", 32'(stop_fetch), 32'd1);
    chk("t2_hold_addr", imem_address, 32'h10);
    id_ready = 1'b1;
    settle();
    chk("t2_pop_req", 32'(imem_req), 32'd0);
    tick();
    id_ready = 1'b0;
    settle();
    chk("t2_after_pop_req", 32'(imem_req), 32'd1);
    chk("t2_after_pop_addr", imem_address, 32'h10);
    chk("t2_after_pop_stop", 32'(stop_fetch), 32'd0);
    tick();

    // Flush while waiting for the read at 0x10
    flush = 1'b1; target = 32'h100; exp_q.delete();
    settle();
    chk("t3_flush_stop", 32'(stop_fetch), 32'd0);
    chk("t3_flush_req", 32'(imem_req), 32'd0);
    tick();
    flush = 1'b0;
    settle();
    chk("t3_drop_valid", 32'(id_valid), 32'd0);
    chk("t3_drop_req", 32'(imem_req), 32'd0);
    chk("t3_drop_stop", 32'(stop_fetch), 32'd1);
    tick();
    imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    settle();
    chk("t3_stale_req", 32'(imem_req), 32'd0);
    tick();
    imem_rvalid = 1'b0;
    settle();
    chk("t3_target_req", 32'(imem_req), 32'd1);
    chk("t3_target_addr", imem_address, 32'h100);
    chk("t3_no_push", 32'(id_valid), 32'd0);
    tick();

    // Two buffered entries, then flush together with rvalid and id_ready
    imem_rvalid = 1'b1; imem_rdata = 32'h1111_1111; exp_push(32'h100, 32'h1111_1111);
    tick();
    imem_rvalid = 1'b0;
    settle();
    chk("t4_addr104", imem_address, 32'h104);
    tick();
    imem_rvalid = 1'b1; imem_rdata = 32'h2222_2222; exp_push(32'h104, 32'h2222_2222);
    tick();
    imem_rvalid = 1'b0;
    settle();
    chk("t4_addr108", imem_address, 32'h108);
    chk("t4_two_valid", 32'(id_valid), 32'd1);
    tick();
    flush = 1'b1; target = 32'h200; imem_rvalid = 1'b1; imem_rdata = 32'h3333_3333;
    id_ready = 1'b1; exp_q.delete();
    settle();
    chk("t4_flush_stop", 32'(stop_fetch), 32'd0);
    chk("t4_flush_req", 32'(imem_req), 32'd0);
    tick();
    flush = 1'b0; imem_rvalid = 1'b0; id_ready = 1'b0;

    // Variable latency: memory not ready for 3 cycles, data 5 cycles later
    imem_ready = 1'b0;
    settle();
    chk("t4_empty", 32'(id_valid), 32'd0);
    for (int i = 0; i < 3; i++) begin
      settle();
      chk("t5_busy_req", 32'(imem_req), 32'd1);
      chk("t5_busy_stop", 32'(stop_fetch), 32'd1);
      chk("t5_busy_addr", imem_address, 32'h200);
      tick();
    end
    imem_ready = 1'b1;
    settle();
    chk("t5_accept_stop", 32'(stop_fetch), 32'd0);
    tick();
    for (int i = 0; i < 4; i++) begin
      settle();
      chk("t5_lat_stop", 32'(stop_fetch), 32'd1);
      chk("t5_lat_req", 32'(imem_req), 32'd0);
      tick();
    end
    imem_rvalid = 1'b1; imem_rdata = 32'h4444_4444; exp_push(32'h200, 32'h4444_4444);
    settle();
    chk("t5_rv_stop", 32'(stop_fetch), 32'd1);
    tick();
    imem_rvalid = 1'b0; chip_enable = 1'b0;
    settle();
    chk("t5_pc_plus4", imem_address, 32'h204);
    chk("t5_one_entry", 32'(id_valid), 32'd1);
    chk("t5_ce0_req", 32'(imem_req), 32'd0);
    chk("t5_ce0_stop", 32'(stop_fetch), 32'd1);
    id_ready = 1'b1;
    tick();
    id_ready = 1'b0;
    settle();
    chk("t5_drained", 32'(id_valid), 32'd0);
    tick();

    // Async reset while a read is outstanding
    chip_enable = 1'b1;
    settle();
    chk("t6_req204", 32'(imem_req), 32'd1);
    chk("t6_addr204", imem_address, 32'h204);
    tick();
    imem_rvalid = 1'b1; imem_rdata = 32'h5555_5555; exp_push(32'h204, 32'h5555_5555);
    tick();
    imem_rvalid = 1'b0;
    settle();
    chk("t6_addr208", imem_address, 32'h208);
    tick();
    #2;
    reset = 1'b0;
    #1;
    chk("t6_rst_valid", 32'(id_valid), 32'd0);
    chk("t6_rst_req", 32'(imem_req), 32'd0);
    chk("t6_rst_stop", 32'(stop_fetch), 32'd1);
    exp_q.delete();
    tick();
    tick();
    chip_enable = 1'b0; reset = 1'b1;
    imem_rvalid = 1'b1; imem_rdata = 32'h6666_6666;
    settle();
    chk("t6_late_req", 32'(imem_req), 32'd0);
    tick();
    imem_rvalid = 1'b0;
    settle();
    chk("t6_late_ignored", 32'(id_valid), 32'd0);
    program_counter = 32'h300; chip_enable = 1'b1;
    settle();
    chk("t6_idle_req", 32'(imem_req), 32'd1);
    chk("t6_idle_addr", imem_address, 32'h300);
    chip_enable = 1'b0;
    tick();
    tick();

    chk("sb_leftover", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
